// File: rtl/rf_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter_if
//
// Purpose: bundles every non-clock signal of the register-file write arbiter
// so the core and its environment connect through one port.
//
// Signal summary (direction as seen by the arbiter, i.e. the slave modport):
//   pipe_we/pipe_rd/pipe_wdata   in   writeback-stage write request (unstallable)
//   ll_issue/ll_issue_rd         in   decode issues a long-latency op to rd
//   ll_valid/ll_rd/ll_wdata      in   long-latency unit result
//   ll_ready                     out  result accepted when ll_valid && ll_ready
//   rs1_reg/rs2_reg/rd_reg       in   decode-stage hazard query
//   sb_stall                     out  decode must hold the current instruction
//   wb_hold                      out  pipeline must drop pipe_we next cycle
//   rf_we/rf_rd/rf_wdata         out  single register-file write port
//   busy_mask                    out  registered scoreboard, one bit per xN
// -----------------------------------------------------------------------------
interface rf_write_arbiter_if;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        ll_issue;
    logic [4:0]  ll_issue_rd;
    logic        ll_valid;
    logic [4:0]  ll_rd;
    logic [31:0] ll_wdata;
    logic        ll_ready;
    logic [4:0]  rs1_reg;
    logic [4:0]  rs2_reg;
    logic [4:0]  rd_reg;
    logic        sb_stall;
    logic        wb_hold;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    // Environment side: pipeline, decode and long-latency unit.
    modport master (
        output pipe_we, pipe_rd, pipe_wdata,
        output ll_issue, ll_issue_rd,
        output ll_valid, ll_rd, ll_wdata,
        output rs1_reg, rs2_reg, rd_reg,
        input  ll_ready, sb_stall, wb_hold,
        input  rf_we, rf_rd, rf_wdata, busy_mask
    );

    // Arbiter side.
    modport slave (
        input  pipe_we, pipe_rd, pipe_wdata,
        input  ll_issue, ll_issue_rd,
        input  ll_valid, ll_rd, ll_wdata,
        input  rs1_reg, rs2_reg, rd_reg,
        output ll_ready, sb_stall, wb_hold,
        output rf_we, rf_rd, rf_wdata, busy_mask
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose: shares one register-file write port between the unstallable
// writeback pipe and a buffered long-latency unit. Long-latency results wait
// in a small FIFO and drain whenever the pipe is idle; if the pipe starves the
// FIFO for STARVE_LIMIT cycles, a one-cycle wb_hold forces a free slot. A
// scoreboard tracks destinations of outstanding long-latency ops and raises
// sb_stall for decode-stage RAW/WAW hazards.
//
// Parameters:
//   STARVE_LIMIT  blocked cycles tolerated before a hold is forced (>= 1)
//   LL_DEPTH      result FIFO depth, 2 or 4 (power of two: pointers wrap)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   rf_write_arbiter_if.slave (see interface header for signals)
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LL_DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_write_arbiter_if.slave    bus
);

    localparam int PTR_W    = $clog2(LL_DEPTH);
    localparam int CNT_W    = $clog2(LL_DEPTH + 1);
    localparam int STARVE_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT - 1);
    localparam logic [CNT_W-1:0]    FULL_CNT   = CNT_W'(LL_DEPTH);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
    } ll_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // FIFO empty
        ST_WAIT  = 2'd1,   // FIFO holds at least one result
        ST_FORCE = 2'd2    // wb_hold cycle; pipe must be idle next cycle
    } state_e;

    ll_entry_t              fifo_q [LL_DEPTH];
    ll_entry_t              fifo_d [LL_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    state_e                 state_q, state_d;
    logic [STARVE_W-1:0]    starve_q, starve_d;
    logic [31:0]            busy_q, busy_d;

    ll_entry_t head;
    logic      full, empty, push, pop, blocked, issue_set;
    logic      stall_rs1, stall_rs2, stall_rd;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        head  = fifo_q[rd_ptr_q];
        full  = (count_q == FULL_CNT);
        empty = (count_q == '0);

        // ll_ready looks at occupancy only: a full FIFO refuses even when it
        // pops this cycle, so there is never a push-through.
        bus.ll_ready = !rst && !full;
        push         = bus.ll_valid && bus.ll_ready;

        // Pipe always wins the write port; the FIFO drains into idle slots.
        pop     = !bus.pipe_we && !empty;
        blocked = bus.pipe_we && !empty;

        bus.rf_we    = !rst && (bus.pipe_we || (pop && head.rd != 5'd0));
        bus.rf_rd    = bus.pipe_we ? bus.pipe_rd    : head.rd;
        bus.rf_wdata = bus.pipe_we ? bus.pipe_wdata : head.wdata;

        // Scoreboard query uses registered busy bits only; x0 never stalls.
        stall_rs1    = (bus.rs1_reg != 5'd0) && busy_q[bus.rs1_reg];
        stall_rs2    = (bus.rs2_reg != 5'd0) && busy_q[bus.rs2_reg];
        stall_rd     = (bus.rd_reg  != 5'd0) && busy_q[bus.rd_reg];
        bus.sb_stall = !rst && (stall_rs1 || stall_rs2 || stall_rd);

        issue_set = bus.ll_issue && !bus.sb_stall && (bus.ll_issue_rd != 5'd0);

        // FIFO storage and pointers.
        fifo_d   = fifo_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = '{rd: bus.ll_rd, wdata: bus.ll_wdata};
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear is applied before set so a same-cycle issue to the popped
        // register leaves its bit set.
        busy_d = busy_q;
        if (pop && head.rd != 5'd0) begin
            busy_d[head.rd] = 1'b0;
        end
        if (issue_set) begin
            busy_d[bus.ll_issue_rd] = 1'b1;
        end

        // Starvation counter: only blocked WAIT cycles count, and it saturates
        // at STARVE_MAX. It is held through FORCE so a pipe write in the
        // post-FORCE cycle re-enters FORCE immediately.
        starve_d = starve_q;
        if (pop) begin
            starve_d = '0;
        end else if (state_q == ST_WAIT && blocked && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end

        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (push) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (blocked && starve_q == STARVE_MAX) state_d = ST_FORCE;
                else if (count_d == '0)                state_d = ST_IDLE;
            end
            ST_FORCE: begin
                state_d = (count_d == '0) ? ST_IDLE : ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase

        // Decoded from the state register, so wb_hold is a registered output.
        bus.wb_hold   = (state_q == ST_FORCE);
        bus.busy_mask = busy_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    // NOTE: the FIFO storage array is not reset; count_q and the pointers
    // decide which entries are valid, so stale data is never observed.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Self-checking bench for rf_write_arbiter (STARVE_LIMIT=4, LL_DEPTH=2).
// A vector table covers scoreboard and port-select behaviour; hand-written
// sequences cover starvation holds, FIFO full/backpressure and mid-run reset.
// Long-latency results are pushed to an expected-write queue when the bench
// drives them and popped when the arbiter should write them out.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rf_write_arbiter_if bus ();

    rf_write_arbiter #(
        .STARVE_LIMIT (4),
        .LL_DEPTH     (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wdata;
    } ent_t;

    ent_t sb_q[$];

    typedef struct {
        logic        pwe;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        iss;
        logic [4:0]  ird;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rdq;
        logic        e_ready;
        logic        e_stall;
        logic        e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic iss, input logic [4:0] ird,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdq,
                       input logic e_ready, input logic e_stall, input logic e_we,
                       input logic [4:0] e_rd, input logic [31:0] e_data, input logic [31:0] e_busy);
        vec_t v;
        v = '{pwe, prd, pdata, iss, ird, lv, lrd, ldata, rs1, rs2, rdq,
              e_ready, e_stall, e_we, e_rd, e_data, e_busy};
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        bus.pipe_we     = 1'b0;
        bus.pipe_rd     = '0;
        bus.pipe_wdata  = '0;
        bus.ll_issue    = 1'b0;
        bus.ll_issue_rd = '0;
        bus.ll_valid    = 1'b0;
        bus.ll_rd       = '0;
        bus.ll_wdata    = '0;
        bus.rs1_reg     = '0;
        bus.rs2_reg     = '0;
        bus.rd_reg      = '0;
    endtask

    // One clock cycle of pipe/long-latency stimulus. Expected rf_* comes from
    // the bench's queue of accepted results; exp_hold is given by the caller.
    task automatic cycle(input string tag,
                         input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                         input logic exp_hold);
        logic        e_ready, e_we;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        ent_t        h;
        bus.pipe_we    = pwe;
        bus.pipe_rd    = prd;
        bus.pipe_wdata = pdata;
        bus.ll_valid   = lv;
        bus.ll_rd      = lrd;
        bus.ll_wdata   = ldata;
        e_ready = (sb_q.size() < DEPTH);
        e_we    = 1'b0;
        e_rd    = '0;
        e_data  = '0;
        if (pwe) begin
            e_we   = 1'b1;
            e_rd   = prd;
            e_data = pdata;
        end else if (sb_q.size() > 0) begin
            h      = sb_q.pop_front();
            e_we   = (h.rd != 5'd0);
            e_rd   = h.rd;
            e_data = h.wdata;
        end
        if (lv && e_ready) sb_q.push_back(ent_t'{rd: lrd, wdata: ldata});
        @(negedge clk);
        check({tag, " ll_ready"}, 32'(bus.ll_ready), 32'(e_ready));
        check({tag, " rf_we"},    32'(bus.rf_we),    32'(e_we));
        if (e_we) begin
            check({tag, " rf_rd"},    32'(bus.rf_rd), 32'(e_rd));
            check({tag, " rf_wdata"}, bus.rf_wdata,   e_data);
        end
        check({tag, " wb_hold"}, 32'(bus.wb_hold), 32'(exp_hold));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t v;

        // ---------------- reset state ----------------
        idle_inputs();
        rst = 1'b1;
        bus.pipe_we    = 1'b1;     // outputs must stay forced low regardless
        bus.pipe_rd    = 5'd2;
        bus.pipe_wdata = 32'h2222_2222;
        bus.ll_valid   = 1'b1;
        #2;
        check("reset ll_ready",  32'(bus.ll_ready), 32'd0);
        check("reset rf_we",     32'(bus.rf_we),    32'd0);
        check("reset wb_hold",   32'(bus.wb_hold),  32'd0);
        check("reset sb_stall",  32'(bus.sb_stall), 32'd0);
        check("reset busy_mask", bus.busy_mask,     32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        //  pwe prd pdata        iss ird  lv lrd ldata         rs1 rs2 rdq  rdy stl we rd wdata          busy
        add(1, 1, 32'h11,        0, 0,   0, 0, 0,             0, 0, 0,     1, 0, 1, 1, 32'h11,        32'h0);
        add(0, 0, 0,             1, 5,   0, 0, 0,             0, 0, 0,     1, 0, 0, 0, 0,             32'h0);
        add(0, 0, 0,             0, 0,   0, 0, 0,             5, 0, 0,     1, 1, 0, 0, 0,             32'h20);
        add(0, 0, 0,             0, 0,   1, 5, 32'hDEADBEEF,  5, 0, 0,     1, 1, 0, 0, 0,             32'h20);
        add(0, 0, 0,             0, 0,   0, 0, 0,             5, 0, 0,     1, 1, 1, 5, 32'hDEADBEEF,  32'h20);
        add(0, 0, 0,             0, 0,   0, 0, 0,             5, 0, 0,     1, 0, 0, 0, 0,             32'h0);
        add(0, 0, 0,             1, 7,   0, 0, 0,             0, 0, 0,     1, 0, 0, 0, 0,             32'h0);
        add(0, 0, 0,             0, 0,   1, 7, 32'h77,        0, 0, 0,     1, 0, 0, 0, 0,             32'h80);
        add(0, 0, 0,             1, 7,   0, 0, 0,             0, 0, 0,     1, 0, 1, 7, 32'h77,        32'h80);
        add(0, 0, 0,             0, 0,   0, 0, 0,             0, 0, 0,     1, 0, 0, 0, 0,             32'h80);
        add(0, 0, 0,             1, 0,   1, 0, 32'h1234,      0, 0, 0,     1, 0, 0, 0, 0,             32'h80);
        add(0, 0, 0,             0, 0,   0, 0, 0,             0, 0, 0,     1, 0, 0, 0, 0,             32'h80);
        add(0, 0, 0,             1, 9,   0, 0, 0,             7, 0, 0,     1, 1, 0, 0, 0,             32'h80);
        add(0, 0, 0,             0, 0,   0, 0, 0,             0, 0, 0,     1, 0, 0, 0, 0,             32'h80);
        add(1, 0, 32'hAAAAAAAA,  0, 0,   0, 0, 0,             0, 0, 0,     1, 0, 1, 0, 32'hAAAAAAAA,  32'h80);
        add(0, 0, 0,             0, 0,   0, 0, 0,             0, 7, 0,     1, 1, 0, 0, 0,             32'h80);
        add(0, 0, 0,             0, 0,   0, 0, 0,             0, 0, 7,     1, 1, 0, 0, 0,             32'h80);

        foreach (vecs[i]) begin
            v = vecs[i];
            bus.pipe_we     = v.pwe;
            bus.pipe_rd     = v.prd;
            bus.pipe_wdata  = v.pdata;
            bus.ll_issue    = v.iss;
            bus.ll_issue_rd = v.ird;
            bus.ll_valid    = v.lv;
            bus.ll_rd       = v.lrd;
            bus.ll_wdata    = v.ldata;
            bus.rs1_reg     = v.rs1;
            bus.rs2_reg     = v.rs2;
            bus.rd_reg      = v.rdq;
            @(negedge clk);
            check($sformatf("v%0d ll_ready", i),  32'(bus.ll_ready), 32'(v.e_ready));
            check($sformatf("v%0d sb_stall", i),  32'(bus.sb_stall), 32'(v.e_stall));
            check($sformatf("v%0d rf_we", i),     32'(bus.rf_we),    32'(v.e_we));
            if (v.e_we) begin
                check($sformatf("v%0d rf_rd", i),    32'(bus.rf_rd), 32'(v.e_rd));
                check($sformatf("v%0d rf_wdata", i), bus.rf_wdata,   v.e_data);
            end
            check($sformatf("v%0d busy_mask", i), bus.busy_mask, v.e_busy);
            check($sformatf("v%0d wb_hold", i),   32'(bus.wb_hold),  32'd0);
            @(posedge clk);
            #1;
        end
        idle_inputs();

        // ---------------- starvation: hold after 4 blocked cycles ----------------
        cycle("B0", 1, 5'd3, 32'h3000_0000, 1, 5'd10, 32'hA0A0_A0A0, 1'b0);
        for (int c = 1; c <= 5; c++)
            cycle($sformatf("B%0d", c), 1, 5'd3, 32'h3000_0000 + 32'(c), 0, 5'd0, 32'd0, (c == 5));
        cycle("B6", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1'b0);
        for (int c = 7; c <= 9; c++)
            cycle($sformatf("B%0d", c), 1, 5'd3, 32'h3000_0000 + 32'(c), 0, 5'd0, 32'd0, 1'b0);
        cycle("B10", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1'b0);

        // ---------------- protocol violation after FORCE re-enters FORCE ----------------
        cycle("D0", 1, 5'd3, 32'h4000_0000, 1, 5'd14, 32'hD14D_14D1, 1'b0);
        for (int c = 1; c <= 7; c++)
            cycle($sformatf("D%0d", c), 1, 5'd3, 32'h4000_0000 + 32'(c), 0, 5'd0, 32'd0,
                  (c == 5) || (c == 7));
        cycle("D8", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1'b0);

        // ---------------- FIFO fill, backpressure, ordering ----------------
        cycle("C0", 1, 5'd4, 32'h5000_0000, 1, 5'd11, 32'hB1, 1'b0);
        cycle("C1", 1, 5'd4, 32'h5000_0001, 1, 5'd12, 32'hB2, 1'b0);
        cycle("C2", 1, 5'd4, 32'h5000_0002, 1, 5'd13, 32'hB3, 1'b0);
        cycle("C3", 0, 5'd0, 32'd0,         1, 5'd13, 32'hB3, 1'b0);
        cycle("C4", 0, 5'd0, 32'd0,         1, 5'd13, 32'hB3, 1'b0);
        cycle("C5", 0, 5'd0, 32'd0,         0, 5'd0,  32'd0,  1'b0);
        cycle("C6", 0, 5'd0, 32'd0,         0, 5'd0,  32'd0,  1'b0);
        check("C queue drained", 32'(sb_q.size()), 32'd0);

        // ---------------- reset mid-operation ----------------
        bus.ll_issue    = 1'b1;
        bus.ll_issue_rd = 5'd20;
        cycle("E0", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1'b0);
        bus.ll_issue_rd = 5'd21;
        cycle("E1", 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1'b0);
        bus.ll_issue    = 1'b0;
        cycle("E2", 1, 5'd6, 32'h6000_0000, 1, 5'd20, 32'hE20, 1'b0);
        cycle("E3", 1, 5'd6, 32'h6000_0001, 1, 5'd21, 32'hE21, 1'b0);
        check("E busy before reset", bus.busy_mask, 32'h0030_0080);
        bus.rs1_reg = 5'd20;
        #1;
        check("E stall before reset", 32'(bus.sb_stall), 32'd1);
        rst = 1'b1;
        #1;
        check("E rst ll_ready",  32'(bus.ll_ready), 32'd0);
        check("E rst rf_we",     32'(bus.rf_we),    32'd0);
        check("E rst busy_mask", bus.busy_mask,     32'd0);
        check("E rst sb_stall",  32'(bus.sb_stall), 32'd0);
        check("E rst wb_hold",   32'(bus.wb_hold),  32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        sb_q.delete();
        for (int c = 5; c <= 7; c++)
            cycle($sformatf("E%0d", c), 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1'b0);
        check("E busy after release", bus.busy_mask, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive cycles a buffered long-latency result may lose arbitration before a hold is forced.
REQ-002 Parameter LL_DEPTH, default 2: long-latency result buffer entries; legal values 2 or 4.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 pipe_we / pipe_rd / pipe_wdata  input  1/5/32  writeback-stage register write request; it cannot be stalled.
REQ-007 ll_issue / ll_issue_rd  input  1/5  decode issues a long-latency op with this destination.
REQ-008 ll_valid / ll_rd / ll_wdata  input  1/5/32  long-latency unit result.
REQ-009 ll_ready  output  1  result accepted when ll_valid && ll_ready.
REQ-010 rs1_reg / rs2_reg / rd_reg  input  5 each  decode-stage operand and destination query.
REQ-011 sb_stall  output  1  decode must hold the current instruction.
REQ-012 wb_hold  output  1  pipeline must present pipe_we=0 in the next cycle.
REQ-013 rf_we / rf_rd / rf_wdata  output  1/5/32  single register-file write port.
REQ-014 busy_mask  output  32  registered scoreboard; bit i set means xi has an outstanding long-latency write.

Function
REQ-015 Buffer: FIFO of LL_DEPTH {rd, wdata} entries; push on ll_valid && ll_ready; ll_ready = !full, combinational.
REQ-016 Full buffer with a pop in the same cycle: ll_ready SHALL still be 0, with no push-through.
REQ-017 Port select, combinational: pipe_we=1 drives rf_* from pipe_*; otherwise a non-empty FIFO pops its head onto rf_*; otherwise rf_we=0.
REQ-018 Pop with head rd=0: consumes the entry, rf_we=0.
REQ-019 Pipe writes to x0 pass through unchanged.
REQ-020 Latency: a result accepted in cycle N reaches rf_* no earlier than N+1; no same-cycle bypass from ll_* to rf_*.
REQ-021 FSM states:
- IDLE: FIFO empty.
- WAIT: FIFO non-empty.
- FORCE: hold pending.
REQ-022 IDLE->WAIT on push; WAIT->IDLE when the last entry pops with no push.
REQ-023 starve_cnt counts cycles in WAIT where pipe_we=1 blocks the pop; it clears on every pop.
REQ-024 WAIT->FORCE when starve_cnt reaches STARVE_LIMIT-1 while blocked; wb_hold=1 is registered and asserted in the FORCE cycle only.
REQ-025 Cycle after FORCE: pipe_we is guaranteed 0, the head pops, starve_cnt clears, and the FSM goes to WAIT or IDLE by FIFO occupancy.
REQ-026 pipe_we=1 in that post-FORCE cycle is a protocol violation; pipe still wins and the FSM re-enters FORCE.
REQ-027 Scoreboard set: ll_issue with ll_issue_rd!=0 sets busy[ll_issue_rd] at the next edge.
REQ-028 Scoreboard clear: a pop with head rd!=0 clears busy[head rd].
REQ-029 Set and clear of the same bit in one cycle: set wins.
REQ-030 sb_stall = (busy[rs1_reg] | busy[rs2_reg] | busy[rd_reg]), each term masked when its index is 0; combinational from registered busy_mask.
REQ-031 ll_issue while sb_stall=1 is ignored and sets nothing.
REQ-032 The block SHALL NOT check pipe_rd against busy_mask; WAW hazards are prevented by sb_stall.

Reset
REQ-033 While rst=1, all state is cleared asynchronously:
- FIFO empty; busy_mask=0; FSM=IDLE; starve_cnt=0.
- Outputs forced: rf_we=0, ll_ready=0, wb_hold=0, sb_stall=0.
REQ-034 Reset mid-operation discards buffered results and outstanding busy bits without writing them.
REQ-035 First cycle after deassertion: ll_ready=1; rf_* follows pipe_* only.

Verification
REQ-036 Issue x5, then accept result rd=5 data 0xDEADBEEF with pipe idle -> rf_we=1, rf_rd=5 next cycle; busy_mask bit5 set then cleared; sb_stall on rs1=5 high until the pop.
REQ-037 Result accepted while pipe_we=1 on x3 for 10 cycles, STARVE_LIMIT=4 -> wb_hold pulses after 4 blocked cycles; the following idle cycle pops the result.
REQ-038 Fill FIFO to LL_DEPTH under continuous pipe_we -> ll_ready=0; the first pop restores ll_ready=1 the next cycle; no entry lost or duplicated; order preserved.
REQ-039 Issue to x7 in the same cycle a result for x7 pops -> rf write occurs and busy_mask bit7 remains 1.
REQ-040 Result with rd=0 -> entry consumed, rf_we=0, busy_mask unchanged; ll_issue_rd=0 sets no bit.
REQ-041 Assert rst with 2 buffered entries and busy bits set -> immediately FIFO empty, busy_mask=0, rf_we=0; no write after release.
